// File: rtl/config_access_sync.sv
// rtl/config_access_sync.sv - synchronised, stability-filtered config bits with freeze, change pulse and serial readback
module config_access_sync #(
   parameter int NoConfigBits = 8,
   parameter int SyncStages   = 2
) (
   input  logic                    UserCLK,
   input  logic                    resetn,
   input  logic [NoConfigBits-1:0] ConfigBits,
   input  logic                    C_hold,
   input  logic                    C_ser_req,
   output logic [NoConfigBits-1:0] C_bit,
   output logic                    C_changed,
   output logic                    C_ser_data,
   output logic                    C_ser_valid,
   output logic                    C_ser_busy
);

   localparam int CW = $clog2(NoConfigBits);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   logic [SyncStages-1:0][NoConfigBits-1:0] r_sync;
   logic [NoConfigBits-1:0]                 r_prev;
   logic [NoConfigBits-1:0]                 r_cbit;
   logic                                    r_changed;
   logic [NoConfigBits-1:0]                 r_shift;
   logic [CW-1:0]                           r_cnt;
   state_t                                  r_state;
   state_t                                  w_next_state;

   logic [NoConfigBits-1:0] w_sync_q;
   logic                    w_stable;
   logic                    w_update;
   logic                    w_cnt_last;
   logic                    w_ser_valid;
   logic                    w_ser_data;

   assign w_sync_q   = r_sync[SyncStages-1];
   assign w_stable   = (w_sync_q == r_prev);
   assign w_update   = w_stable && (w_sync_q != r_cbit) && !C_hold;
   assign w_cnt_last = (r_cnt == CW'(NoConfigBits - 1));

   // Synchroniser chain plus one-cycle delayed copy for the stability check
   always_ff @(posedge UserCLK) begin
      if (!resetn) begin
         r_sync <= '0;
         r_prev <= '0;
      end else begin
         r_sync <= {r_sync[SyncStages-2:0], ConfigBits};
         r_prev <= w_sync_q;
      end
   end

   // Filtered output register: only accept a value seen on two consecutive cycles
   always_ff @(posedge UserCLK) begin
      if (!resetn) begin
         r_cbit    <= '0;
         r_changed <= 1'b0;
      end else begin
         r_changed <= w_update;
         if (w_update) begin
            r_cbit <= w_sync_q;
         end
      end
   end

   // Readback state register
   always_ff @(posedge UserCLK) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Readback datapath: snapshot C_bit on request, then shift out LSB first
   always_ff @(posedge UserCLK) begin
      if (!resetn) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (r_state == S_IDLE) begin
         if (C_ser_req) begin
            r_shift <= r_cbit;
            r_cnt   <= '0;
         end
      end else begin
         r_shift <= r_shift >> 1;
         if (!w_cnt_last) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Readback next-state and serial outputs
   always_comb begin
      w_next_state = r_state;
      w_ser_valid  = 1'b0;
      w_ser_data   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (C_ser_req) begin
               w_next_state = S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_ser_valid = 1'b1;
            w_ser_data  = r_shift[0];
            if (w_cnt_last) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   assign C_bit       = r_cbit;
   assign C_changed   = r_changed;
   assign C_ser_data  = w_ser_data;
   assign C_ser_valid = w_ser_valid;
   assign C_ser_busy  = w_ser_valid;

endmodule
